// File: rtl/sha256_host_driver_if.sv
// Message-in / digest-out and halfword core bus of the SHA-256 host driver.
// master is the driver side, slave is the host/core side.
interface sha256_host_driver_if;
  logic        msg_start;
  logic [31:0] blk_word;
  logic        blk_valid;
  logic        blk_last;
  logic        blk_ready;
  logic [31:0] digest;
  logic [2:0]  digest_index;
  logic        digest_valid;
  logic        busy;
  logic        err;
  logic        sha_init;
  logic        sha_load;
  logic        sha_fetch;
  logic [15:0] sha_idata;
  logic        sha_ack;
  logic [15:0] sha_odata;

  modport master (
    input  msg_start, blk_word, blk_valid, blk_last,
    input  sha_ack, sha_odata,
    output blk_ready, digest, digest_index, digest_valid,
    output busy, err,
    output sha_init, sha_load, sha_fetch, sha_idata
  );

  modport slave (
    output msg_start, blk_word, blk_valid, blk_last,
    output sha_ack, sha_odata,
    input  blk_ready, digest, digest_index, digest_valid,
    input  busy, err,
    input  sha_init, sha_load, sha_fetch, sha_idata
  );
endinterface

// File: rtl/sha256_host_driver.sv
// Streams pre-padded 32-bit words into a halfword SHA-256 core with
// return-to-zero load/fetch handshakes, then reads back the 8-word digest.
module sha256_host_driver (
  input  logic                        clk,
  input  logic                        rst,
  sha256_host_driver_if.master        bus
);

  typedef enum logic [3:0] {
    IDLE, INIT, GETW, SEND_HI, GAP_HI,
    SEND_LO, GAP_LO, FETCH, FGAP, ERR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] dig_q, dig_d;
  logic [2:0]  didx_q, didx_d;
  logic        dval_q, dval_d;
  logic        req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
      fcnt_q  <= '0;
      tmo_q   <= '0;
      dig_q   <= '0;
      didx_q  <= '0;
      dval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      tmo_q   <= tmo_d;
      dig_q   <= dig_d;
      didx_q  <= didx_d;
      dval_q  <= dval_d;
    end
  end

  assign req = (state_q == SEND_HI) || (state_q == SEND_LO) ||
               (state_q == FETCH);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    dig_d   = dig_q;
    didx_d  = didx_q;
    dval_d  = 1'b0;
    // ack outside a request is ignored: timeout only runs while requesting
    tmo_d   = (req && !bus.sha_ack) ? tmo_q + 8'd1 : 8'd0;
    unique case (state_q)
      IDLE: if (bus.msg_start) state_d = INIT;
      INIT: begin
        wcnt_d  = '0;
        fcnt_d  = '0;
        state_d = GETW;
      end
      GETW: if (bus.blk_valid) begin
        word_d = bus.blk_word;
        if (wcnt_q == 4'd15) last_d = bus.blk_last;
        state_d = SEND_HI;
      end
      SEND_HI: begin
        if (bus.sha_ack)            state_d = GAP_HI;
        else if (tmo_q == 8'd254)   state_d = ERR;
      end
      GAP_HI: state_d = SEND_LO;
      SEND_LO: begin
        if (bus.sha_ack)            state_d = GAP_LO;
        else if (tmo_q == 8'd254)   state_d = ERR;
      end
      GAP_LO: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'd15 && last_q) state_d = FETCH;
        else                           state_d = GETW;
      end
      FETCH: begin
        if (bus.sha_ack) begin
          fcnt_d  = fcnt_q + 4'd1;
          state_d = FGAP;
          if (!fcnt_q[0]) begin
            dig_d[31:16] = bus.sha_odata;
          end else begin
            dig_d[15:0] = bus.sha_odata;
            didx_d      = fcnt_q[3:1];
            dval_d      = 1'b1;
          end
        end else if (tmo_q == 8'd254) begin
          state_d = ERR;
        end
      end
      // fetch count wraps to zero only after the 16th halfword
      FGAP: state_d = (fcnt_q == 4'd0) ? IDLE : FETCH;
      ERR:  state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  assign bus.blk_ready    = (state_q == GETW);
  assign bus.sha_init     = (state_q == INIT);
  assign bus.sha_load     = (state_q == SEND_HI) || (state_q == SEND_LO);
  assign bus.sha_fetch    = (state_q == FETCH);
  assign bus.sha_idata    = (state_q == SEND_HI) ? word_q[31:16] :
                            (state_q == SEND_LO) ? word_q[15:0]  : 16'h0;
  assign bus.busy         = (state_q != IDLE) && (state_q != ERR);
  assign bus.err          = (state_q == ERR);
  assign bus.digest       = dig_q;
  assign bus.digest_index = didx_q;
  assign bus.digest_valid = dval_q;

endmodule

// File: tb/tb_sha256_host_driver.sv
// Bench for sha256_host_driver: behavioural SHA-256 halfword core,
// digest scoreboard against published test vectors.
module tb_sha256_host_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  sha256_host_driver_if tif();

  sha256_host_driver dut (
    .clk (clk),
    .rst (rst),
    .bus (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] kc [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [31:0] iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic [31:0] dig_abc [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic [31:0] dig_two [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};

  logic [31:0] hs [8];
  logic [15:0] blkh [32];
  int hidx, fidx;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic sha_blk();
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = {blkh[2*i], blkh[2*i+1]};
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = hs[0]; b = hs[1]; c = hs[2]; d = hs[3];
    e = hs[4]; f = hs[5]; g = hs[6]; h = hs[7];
    for (int i = 0; i < 64; i++) begin
      s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + kc[i] + w[i];
      s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    hs[0] += a; hs[1] += b; hs[2] += c; hs[3] += d;
    hs[4] += e; hs[5] += f; hs[6] += g; hs[7] += h;
  endtask

  // core responder and protocol observers
  int inits, loads, fetches, stab_err, gap_err, first_fetch_loads;
  int dly_mode = 0;
  int hold_load = -1;
  int wait_cnt, cur_dly, req_cyc;
  logic prev_req, req;
  logic [15:0] held;
  logic [15:0] rec [2];

  task automatic clr_stats();
    inits = 0; loads = 0; fetches = 0;
    stab_err = 0; gap_err = 0; first_fetch_loads = -1;
    rec[0] = '0; rec[1] = '0;
  endtask

  initial begin
    tif.sha_ack = 1'b0;
    tif.sha_odata = '0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tif.sha_ack = 1'b0;
        prev_req = 1'b0;
        continue;
      end
      if (tif.sha_init) begin
        inits++;
        hs = iv; hidx = 0; fidx = 0;
      end
      req = tif.sha_load || tif.sha_fetch;
      if (tif.sha_ack) begin
        tif.sha_ack = 1'b0;
        if (req) gap_err++;
        prev_req = 1'b0;
        continue;
      end
      if (req && !prev_req) begin
        req_cyc = cyc;
        held = tif.sha_idata;
        wait_cnt = 0;
        cur_dly = dly_mode ? int'($urandom_range(20, 0)) : 1;
      end else if (req && tif.sha_idata !== held) begin
        stab_err++;
      end
      if (req && !(tif.sha_load && loads == hold_load)) begin
        if (wait_cnt >= cur_dly) begin
          if (tif.sha_load) begin
            if (loads < 2) rec[loads] = tif.sha_idata;
            blkh[hidx] = tif.sha_idata;
            loads++; hidx++;
            if (hidx == 32) begin sha_blk(); hidx = 0; end
          end else begin
            if (first_fetch_loads < 0) first_fetch_loads = loads;
            tif.sha_odata = fidx[0] ? hs[fidx>>1][15:0] : hs[fidx>>1][31:16];
            fidx++; fetches++;
          end
          tif.sha_ack = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
      prev_req = req;
    end
  end

  // digest scoreboard
  logic [34:0] sb [$];
  logic [34:0] sb_e;

  task automatic push_dig(input logic [31:0] v [8]);
    for (int i = 0; i < 8; i++) sb.push_back({3'(i), v[i]});
  endtask

  always @(negedge clk) begin
    if (!rst && tif.digest_valid) begin
      if (sb.size() == 0) begin
        check("dig_extra", 64'(tif.digest), 64'(0));
      end else begin
        sb_e = sb.pop_front();
        check("digest", 64'(tif.digest), 64'(sb_e[31:0]));
        check("dig_idx", 64'(tif.digest_index), 64'(sb_e[34:32]));
      end
    end
  end

  // message driver
  logic [31:0] msg [32];
  logic abort = 1'b0;

  task automatic load_abc();
    for (int i = 0; i < 32; i++) msg[i] = '0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  task automatic load_two();
    logic [31:0] m [14] = '{
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071};
    for (int i = 0; i < 32; i++) msg[i] = '0;
    for (int i = 0; i < 14; i++) msg[i] = m[i];
    msg[14] = 32'h80000000;
    msg[31] = 32'h000001c0;
  endtask

  task automatic send_msg(input int nblk);
    int n;
    @(negedge clk);
    tif.msg_start = 1'b1;
    @(negedge clk);
    tif.msg_start = 1'b0;
    for (int i = 0; i < nblk * 16 && !abort; i++) begin
      tif.blk_word = msg[i];
      // blk_last only matters on word 15: drive it high elsewhere too
      tif.blk_last = (i / 16 == nblk - 1) || (i % 16 != 15);
      tif.blk_valid = 1'b1;
      n = 0;
      while (!tif.blk_ready && !abort && n < 3000) begin
        @(negedge clk); n++;
      end
      if (n >= 3000) begin
        check("blk_timeout", 64'(n), 64'(0));
        abort = 1'b1;
      end
      @(negedge clk);
      tif.blk_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || tif.busy) && n < 8000) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [63:0] outs();
    return 64'({tif.blk_ready, tif.digest, tif.digest_index,
                tif.digest_valid, tif.busy, tif.err, tif.sha_init,
                tif.sha_load, tif.sha_fetch, tif.sha_idata});
  endfunction

  task automatic run_abc(input string tag);
    clr_stats();
    load_abc();
    push_dig(dig_abc);
    send_msg(1);
    wait_done(tag);
    check({tag, "_inits"}, 64'(inits), 64'(1));
    check({tag, "_loads"}, 64'(loads), 64'(32));
    check({tag, "_fetches"}, 64'(fetches), 64'(16));
    check({tag, "_stable"}, 64'(stab_err), 64'(0));
    check({tag, "_gap"}, 64'(gap_err), 64'(0));
  endtask

  int n;
  int t0;

  initial begin
    tif.msg_start = 1'b0;
    tif.blk_word = '0;
    tif.blk_valid = 1'b0;
    tif.blk_last = 1'b0;
    clr_stats();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_outs", outs(), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", outs(), 64'(0));

    // ignored inputs while idle
    tif.blk_valid = 1'b1;
    repeat (3) @(negedge clk);
    tif.blk_valid = 1'b0;
    check("idle_ignore", outs(), 64'(0));

    // "abc", single block, ack one cycle after request
    run_abc("abc");
    check("abc_hw0", 64'(rec[0]), 64'(16'h6162));
    check("abc_hw1", 64'(rec[1]), 64'(16'h6380));

    // two-block message
    clr_stats();
    load_two();
    push_dig(dig_two);
    send_msg(2);
    wait_done("two");
    check("two_inits", 64'(inits), 64'(1));
    check("two_loads", 64'(loads), 64'(64));
    check("two_fetches", 64'(fetches), 64'(16));
    check("two_fetch_after", 64'(first_fetch_loads), 64'(64));

    // random ack delay
    dly_mode = 1;
    run_abc("rnd");
    dly_mode = 0;

    // msg_start during fetch is ignored
    clr_stats();
    load_abc();
    push_dig(dig_abc);
    fork
      send_msg(1);
      begin
        n = 0;
        while (!tif.sha_fetch && n < 3000) begin @(negedge clk); n++; end
        tif.msg_start = 1'b1;
        @(negedge clk);
        tif.msg_start = 1'b0;
      end
    join
    wait_done("mid_start");
    check("mid_start_inits", 64'(inits), 64'(1));

    // reset during SEND_LO of word 7, then full block again
    clr_stats();
    load_abc();
    fork
      send_msg(1);
      begin
        n = 0;
        do begin
          @(negedge clk); #2; n++;
        end while (!(loads == 15 && tif.sha_load) && n < 3000);
        rst = 1'b1;
        abort = 1'b1;
        #1;
        check("rst_async", outs(), 64'(0));
      end
    join
    repeat (2) @(negedge clk);
    check("rst_hold", outs(), 64'(0));
    rst = 1'b0;
    abort = 1'b0;
    check("rst_no_dig", 64'(sb.size()), 64'(0));
    run_abc("after_rst");

    // ack withheld on the 5th load -> timeout
    clr_stats();
    load_abc();
    hold_load = 4;
    fork
      send_msg(1);
      begin
        n = 0;
        while (!tif.err && n < 2000) begin @(negedge clk); n++; end
        t0 = cyc - req_cyc;
        abort = 1'b1;
      end
    join
    check("tmo_cycles", 64'(t0), 64'(255));
    check("tmo_loads", 64'(loads), 64'(4));
    check("err_flags", 64'({tif.err, tif.busy, tif.sha_load,
                            tif.sha_fetch, tif.blk_ready}),
          64'(5'b10000));
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(tif.err), 64'(1));
    hold_load = -1;
    abort = 1'b0;
    rst = 1'b1;
    #1;
    check("err_clr", outs(), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
